// File: rtl/hub75_rx.sv
// HUB75 receiver: rebuilds shifted lines in a ping-pong buffer and streams each latched line as pixel beats.
// Optional: define HUB75_RX_BLANK_GATE_EN to accept a latch only while the panel is blanked.
module hub75_rx #(
    parameter int COLS     = 32,
    parameter int COLBITS  = 5,
    parameter int ADDRBITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hub_sclk,
    input  logic                hub_latch,
    input  logic                hub_blank,
    input  logic [ADDRBITS-1:0] hub_addr,
    input  logic [2:0]          hub_rgb1,
    input  logic [2:0]          hub_rgb2,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [ADDRBITS-1:0] px_row,
    output logic [COLBITS-1:0]  px_col,
    output logic [2:0]          px_rgb1,
    output logic [2:0]          px_rgb2,
    output logic                px_last,
    output logic                overrun
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DUMP = 1'b1;
    localparam int DW = ADDRBITS + 8;
    localparam logic [COLBITS:0] COLS_W = (COLBITS+1)'(COLS);

    // {sclk, latch, addr, rgb1, rgb2} share one synchroniser so data and strobes stay aligned
    logic [DW-1:0]         s1_q, s2_q;
    logic [1:0]            s2d_q;
    logic [COLBITS:0]      wr_col_q, wr_col_d, wr_cnt, len_q, len_d;
    logic [COLBITS-1:0]    rd_col_q, rd_col_d;
    logic [ADDRBITS-1:0]   row_q, row_d;
    logic [0:0]            state_q, state_d;
    logic                  bank_sel_q, bank_sel_d;
    logic                  go_q, go_d, overrun_q, overrun_d;
    logic                  sclk_rise, latch_rise, latch_ok, cap_en, latch_hit, busy, accept, last_beat;
    logic [5:0]            s2_pix, rd_dat;
    logic [ADDRBITS-1:0]   s2_addr;
    logic [5:0]            mem_q [2][COLS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s2d_q <= '0;
        end else begin
            s1_q  <= {hub_sclk, hub_latch, hub_addr, hub_rgb1, hub_rgb2};
            s2_q  <= s1_q;
            s2d_q <= s2_q[DW-1 -: 2];
        end
    end

    assign sclk_rise  = s2_q[DW-1] & ~s2d_q[1];
    assign latch_rise = s2_q[DW-2] & ~s2d_q[0];
    assign s2_addr    = s2_q[ADDRBITS+5:6];
    assign s2_pix     = s2_q[5:0];

`ifdef HUB75_RX_BLANK_GATE_EN
    logic blank_s1_q, blank_s2_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_s1_q <= 1'b0;
            blank_s2_q <= 1'b0;
        end else begin
            blank_s1_q <= hub_blank;
            blank_s2_q <= blank_s1_q;
        end
    end
    assign latch_ok = latch_rise & blank_s2_q;
`else
    logic unused_blank;
    assign unused_blank = hub_blank;
    assign latch_ok     = latch_rise;
`endif

    // A pixel shifted in the latch cycle is written first and counted in the line
    assign cap_en    = sclk_rise && (wr_col_q < COLS_W);
    assign wr_cnt    = wr_col_q + {{COLBITS{1'b0}}, cap_en};
    assign latch_hit = latch_ok && (wr_cnt != '0);
    assign busy      = (state_q == S_DUMP) || go_q;
    assign accept    = latch_hit && !busy;
    assign last_beat = ({1'b0, rd_col_q} == (len_q - (COLBITS+1)'(1)));

    always_ff @(posedge clk) begin
        if (cap_en) mem_q[bank_sel_q][wr_col_q[COLBITS-1:0]] <= s2_pix;
    end
    assign rd_dat = mem_q[~bank_sel_q][rd_col_q];

    always_comb begin
        wr_col_d   = latch_hit ? '0 : wr_cnt;
        bank_sel_d = accept ? ~bank_sel_q : bank_sel_q;
        row_d      = accept ? s2_addr : row_q;
        len_d      = accept ? wr_cnt : len_q;
        go_d       = accept;
        overrun_d  = latch_hit && busy;
        state_d    = state_q;
        rd_col_d   = rd_col_q;
        case (state_q)
            S_IDLE: if (go_q) state_d = S_DUMP;
            S_DUMP: begin
                if (px_ready) begin
                    if (last_beat) begin
                        rd_col_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        rd_col_d = rd_col_q + COLBITS'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_col_q   <= '0;
            rd_col_q   <= '0;
            len_q      <= '0;
            row_q      <= '0;
            bank_sel_q <= 1'b0;
            go_q       <= 1'b0;
            overrun_q  <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            wr_col_q   <= wr_col_d;
            rd_col_q   <= rd_col_d;
            len_q      <= len_d;
            row_q      <= row_d;
            bank_sel_q <= bank_sel_d;
            go_q       <= go_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
        end
    end

    assign px_valid = (state_q == S_DUMP);
    assign px_row   = row_q;
    assign px_col   = rd_col_q;
    assign px_rgb1  = px_valid ? rd_dat[5:3] : 3'b0;
    assign px_rgb2  = px_valid ? rd_dat[2:0] : 3'b0;
    assign px_last  = px_valid && last_beat;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: drives HUB75 lines, scoreboards expected beats and overrun pulses.
module tb_hub75_rx;
    localparam int COLS = 32, COLBITS = 5, ADDRBITS = 5;

    logic                clk = 1'b0, reset = 1'b1;
    logic                hub_sclk = 1'b0, hub_latch = 1'b0, hub_blank = 1'b1;
    logic [ADDRBITS-1:0] hub_addr = '0;
    logic [2:0]          hub_rgb1 = '0, hub_rgb2 = '0;
    logic                px_valid, px_ready = 1'b1, px_last, overrun;
    logic [ADDRBITS-1:0] px_row;
    logic [COLBITS-1:0]  px_col;
    logic [2:0]          px_rgb1, px_rgb2;

    hub75_rx #(.COLS(COLS), .COLBITS(COLBITS), .ADDRBITS(ADDRBITS)) dut (
        .clk(clk), .reset(reset), .hub_sclk(hub_sclk), .hub_latch(hub_latch),
        .hub_blank(hub_blank), .hub_addr(hub_addr), .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
        .px_valid(px_valid), .px_ready(px_ready), .px_row(px_row), .px_col(px_col),
        .px_rgb1(px_rgb1), .px_rgb2(px_rgb2), .px_last(px_last), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDRBITS-1:0] row;
        logic [COLBITS-1:0]  col;
        logic [2:0]          r1;
        logic [2:0]          r2;
        logic                last;
    } beat_t;

    beat_t exp_q[$];
    logic [5:0] mdl_line [COLS];
    int mdl_cnt = 0, ovr_exp = 0, ovr_seen = 0;
    int n_chk = 0, n_fail = 0;
    logic hold_vld = 1'b0, ovr_prev = 1'b0;
    beat_t hold_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_add(input logic [2:0] a, input logic [2:0] b);
        if (mdl_cnt < COLS) begin
            mdl_line[mdl_cnt] = {a, b};
            mdl_cnt++;
        end
    endtask

    task automatic mdl_latch(output bit started);
        beat_t bt;
        started = 1'b0;
`ifdef HUB75_RX_BLANK_GATE_EN
        if (!hub_blank) return;
`endif
        if (mdl_cnt == 0) return;
        if (exp_q.size() != 0) begin
            ovr_exp++;
        end else begin
            started = 1'b1;
            for (int i = 0; i < mdl_cnt; i++) begin
                bt.row  = hub_addr;
                bt.col  = COLBITS'(i);
                bt.r1   = mdl_line[i][5:3];
                bt.r2   = mdl_line[i][2:0];
                bt.last = (i == mdl_cnt - 1);
                exp_q.push_back(bt);
            end
        end
        mdl_cnt = 0;
    endtask

    task automatic shift_px(input logic [2:0] a, input logic [2:0] b);
        mdl_add(a, b);
        hub_rgb1 = a; hub_rgb2 = b; hub_sclk = 1'b1;
        tick(); tick();
        hub_sclk = 1'b0;
        tick(); tick();
    endtask

    // Valid must appear exactly on the 4th edge after latch goes high
    task automatic do_latch();
        bit started;
        mdl_latch(started);
        hub_latch = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) hub_latch = 1'b0;
            if (started) chk($sformatf("latency_e%0d", k), px_valid, (k == 4));
        end
    endtask

    task automatic latch_with_px(input logic [2:0] a, input logic [2:0] b);
        bit started;
        mdl_add(a, b);
        mdl_latch(started);
        hub_rgb1 = a; hub_rgb2 = b; hub_sclk = 1'b1; hub_latch = 1'b1;
        tick(); tick();
        hub_sclk = 1'b0; hub_latch = 1'b0;
        tick(); tick();
    endtask

    task automatic shift_line(input int n, input int salt);
        int v;
        for (int c = 0; c < n; c++) begin
            v = c + salt;
            shift_px(3'(v), 3'(~v));
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || px_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_col(input logic [COLBITS-1:0] c);
        int n = 0;
        while (!(px_valid && px_col == c) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_col", px_col, c);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_vld"}, px_valid, 0);
        chk({tag, "_last"}, px_last, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_row"}, px_row, 0);
        chk({tag, "_col"}, px_col, 0);
        chk({tag, "_rgb1"}, px_rgb1, 0);
        chk({tag, "_rgb2"}, px_rgb2, 0);
    endtask

    always @(negedge clk) begin
        beat_t cur, e;
        if (reset) begin
            hold_vld = 1'b0;
            ovr_prev = 1'b0;
        end else begin
            cur = {px_row, px_col, px_rgb1, px_rgb2, px_last};
            if (hold_vld) begin
                chk("hold_vld", px_valid, 1);
                chk("hold_beat", cur, hold_b);
            end
            if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", px_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_row", px_row, e.row);
                    chk("beat_col", px_col, e.col);
                    chk("beat_rgb1", px_rgb1, e.r1);
                    chk("beat_rgb2", px_rgb2, e.r2);
                    chk("beat_last", px_last, e.last);
                end
            end
            hold_vld = px_valid && !px_ready;
            hold_b   = cur;
            if (overrun) begin
                chk("ovr_width", ovr_prev, 0);
                ovr_seen++;
            end
            ovr_prev = overrun;
        end
    end

    initial begin
        repeat (3) tick();
        chk_idle_outs("reset");
        reset = 1'b0;
        tick();

        hub_addr = 5'd5;
        shift_line(32, 0);
        do_latch();
        wait_drain("line32");

        hub_addr = 5'd9;
        shift_line(40, 3);
        do_latch();
        wait_drain("line40");

        hub_addr = 5'd12;
        shift_line(32, 5);
        do_latch();
        wait_col(5'd7);
        px_ready = 1'b0;
        repeat (10) tick();
        chk("stall_col", px_col, 7);
        chk("stall_vld", px_valid, 1);
        px_ready = 1'b1;
        wait_drain("stall");

        px_ready = 1'b0;
        hub_addr = 5'd3;
        shift_line(32, 1);
        do_latch();
        hub_addr = 5'd4;
        shift_line(32, 6);
        do_latch();
        repeat (4) tick();
        chk("ovr_count_a", ovr_seen, ovr_exp);
        chk("ovr_count_one", ovr_seen, 1);
        px_ready = 1'b1;
        wait_drain("overrun");

        hub_addr = 5'd6;
        shift_line(32, 2);
        do_latch();
        wait_drain("seq_a");
        hub_addr = 5'd7;
        shift_line(32, 4);
        do_latch();
        wait_drain("seq_b");

        hub_addr = 5'd1;
        do_latch();
        repeat (8) tick();
        chk("empty_latch_vld", px_valid, 0);
        hub_addr = 5'd2;
        shift_line(3, 7);
        latch_with_px(3'd5, 3'd2);
        wait_drain("same_cycle");

        hub_addr = 5'd8;
        shift_line(32, 3);
        do_latch();
        wait_col(5'd10);
        reset = 1'b1;
        tick();
        chk_idle_outs("mid_reset");
        exp_q.delete();
        mdl_cnt = 0;
        reset = 1'b0;
        tick();
        hub_addr = 5'd10;
        shift_line(32, 6);
        do_latch();
        wait_drain("after_reset");

`ifdef HUB75_RX_BLANK_GATE_EN
        hub_addr = 5'd11;
        shift_line(32, 2);
        hub_blank = 1'b0;
        do_latch();
        repeat (10) tick();
        chk("gate_unblanked_vld", px_valid, 0);
        hub_blank = 1'b1;
        do_latch();
        wait_drain("gate_blanked");
`endif

        repeat (4) tick();
        chk("ovr_count_end", ovr_seen, ovr_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
